// File: rtl/joy_db15_scan.sv
// DB15 joystick adapter scanner: parallel-loads the 32-bit button chain, clocks it out
// serially and publishes both players' buttons atomically once per frame.
module joy_db15_scan #(
   parameter int unsigned DIV = 25,
   parameter int unsigned GAP = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        joy_data,
   output logic        joy_clk,
   output logic        joy_load,
   output logic [15:0] joystick1,
   output logic [15:0] joystick2,
   output logic        present,
   output logic        scan_done
);

   localparam logic [7:0] DivLast = 8'(DIV - 1);
   localparam logic [9:0] GapLast = 10'(GAP - 1);

   typedef enum logic [2:0] {
      StLoad,
      StShiftLo,
      StShiftHi,
      StPublish,
      StGap
   } state_t;

   state_t      state;
   logic [7:0]  div_cnt;
   logic [4:0]  bit_idx;
   logic [9:0]  gap_cnt;
   logic [31:0] shift;
   logic        started;
   logic        data_meta;
   logic        data_sync;
   logic        tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         data_meta <= joy_data;
         data_sync <= data_meta;
      end
   end

   // The divider idles for the start clk after reset and during the single PUBLISH clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (started && state != StPublish) begin
         div_cnt <= (div_cnt == DivLast) ? 8'd0 : div_cnt + 8'd1;
      end
   end

   assign tick = started && (state != StPublish) && (div_cnt == DivLast);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StLoad;
         started   <= 1'b0;
         bit_idx   <= '0;
         gap_cnt   <= '0;
         shift     <= '0;
         joy_clk   <= 1'b1;
         joy_load  <= 1'b1;
         joystick1 <= '0;
         joystick2 <= '0;
         present   <= 1'b0;
         scan_done <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         case (state)
            StLoad: begin
               if (!started) begin
                  started  <= 1'b1;
                  joy_load <= 1'b0;
                  joy_clk  <= 1'b1;
               end else if (tick) begin
                  state    <= StShiftLo;
                  bit_idx  <= '0;
                  joy_load <= 1'b1;
                  joy_clk  <= 1'b0;
               end
            end
            StShiftLo: begin
               if (tick) begin
                  shift[bit_idx] <= ~data_sync;
                  joy_clk        <= 1'b1;
                  state          <= StShiftHi;
               end
            end
            StShiftHi: begin
               if (tick) begin
                  if (bit_idx == 5'd31) begin
                     state <= StPublish;
                  end else begin
                     bit_idx <= bit_idx + 5'd1;
                     joy_clk <= 1'b0;
                     state   <= StShiftLo;
                  end
               end
            end
            StPublish: begin
               // All samples pressed means joy_data stuck low: no adapter or a short.
               if (&shift) begin
                  present   <= 1'b0;
                  joystick1 <= '0;
                  joystick2 <= '0;
               end else begin
                  present   <= 1'b1;
                  joystick1 <= shift[15:0];
                  joystick2 <= shift[31:16];
               end
               scan_done <= 1'b1;
               gap_cnt   <= '0;
               state     <= StGap;
            end
            StGap: begin
               if (tick) begin
                  if (gap_cnt == GapLast) begin
                     gap_cnt  <= '0;
                     joy_load <= 1'b0;
                     state    <= StLoad;
                  end else begin
                     gap_cnt <= gap_cnt + 10'd1;
                  end
               end
            end
            default: state <= StLoad;
         endcase
      end
   end

endmodule

// File: tb/tb_joy_db15_scan.sv
// Bench for joy_db15_scan: two instances (default and minimum timing) against a
// behavioural DB15 chain model, with a scoreboard fed at each end of parallel load.
module tb_joy_db15_scan;

   typedef struct packed {
      logic [15:0] j1;
      logic [15:0] j2;
      logic        pr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned cyc = 0;

   always #10 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic exp_t model(input logic [31:0] pressed, input logic stuck);
      exp_t e;
      if (stuck || pressed == 32'hFFFF_FFFF) begin
         e = '0;
      end else begin
         e.j1 = pressed[15:0];
         e.j2 = pressed[31:16];
         e.pr = 1'b1;
      end
      return e;
   endfunction

   task automatic check(input string name, input int inst, input logic [32:0] got,
                        input logic [32:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s u%0d got=%h required=%h t=%0t", name, inst, got, req, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int unsigned D = (g == 0) ? 25 : 2;
      localparam int unsigned G = (g == 0) ? 64 : 1;
      localparam int unsigned Period = (1 + 64 + G) * D + 1;

      logic        joy_data;
      logic        joy_clk;
      logic        joy_load;
      logic        present;
      logic        scan_done;
      logic [15:0] joystick1;
      logic [15:0] joystick2;

      logic [31:0] pat = '0;
      logic        stuck = 1'b0;
      logic [31:0] chain = '1;
      logic [31:0] pat_lat = '0;
      logic        stuck_lat = 1'b0;
      exp_t        q[$];
      exp_t        last = '0;
      int unsigned scans = 0;
      int unsigned last_pulse = 0;
      int unsigned load_run = 0;
      int unsigned lo_run = 0;
      int unsigned hi_run = 0;
      int unsigned rises = 0;
      logic        prev_clk = 1'b1;
      logic        prev_load = 1'b1;

      joy_db15_scan #(.DIV(D), .GAP(G)) dut (
         .clk      (clk),
         .reset    (reset),
         .joy_data (joy_data),
         .joy_clk  (joy_clk),
         .joy_load (joy_load),
         .joystick1(joystick1),
         .joystick2(joystick2),
         .present  (present),
         .scan_done(scan_done)
      );

      // Chain: active-low buttons, bit 0 presented first, shifts on rising joy_clk.
      assign joy_data = stuck ? 1'b0 : chain[0];

      always @(posedge joy_clk or negedge joy_load) begin
         if (!joy_load) begin
            chain     <= ~pat;
            pat_lat   <= pat;
            stuck_lat <= stuck;
         end else begin
            chain <= {1'b1, chain[31:1]};
         end
      end

      always @(posedge joy_load) if (!reset) q.push_back(model(pat_lat, stuck_lat));
      always @(posedge reset) q.delete();

      always @(negedge clk) begin
         exp_t e;
         if (reset) begin
            last = '0; scans = 0; load_run = 0; lo_run = 0; hi_run = 0; rises = 0;
            prev_clk = 1'b1; prev_load = 1'b1;
         end else begin
            if (!joy_load) begin
               load_run++;
               rises = 0;
            end else if (!prev_load) begin
               check("load_low_len", g, 33'(load_run), 33'(D));
               load_run = 0;
            end
            if (!joy_clk) begin
               if (prev_clk && rises >= 1 && rises <= 31)
                  check("clk_high_len", g, 33'(hi_run), 33'(D));
               lo_run++;
            end else begin
               if (!prev_clk) begin
                  check("clk_low_len", g, 33'(lo_run), 33'(D));
                  rises++;
                  lo_run = 0;
                  hi_run = 1;
               end else begin
                  hi_run++;
               end
            end
            if (scan_done) begin
               if (scans > 0) check("frame_period", g, 33'(cyc - last_pulse), 33'(Period));
               last_pulse = cyc;
               check("rises_per_frame", g, 33'(rises), 33'd32);
               if (q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL frame u%0d got=scan_done required=no_pending_frame", g);
               end else begin
                  e = q.pop_front();
                  check("frame", g, {joystick1, joystick2, present}, e);
                  last = e;
               end
               scans++;
            end else begin
               check("stable", g, {joystick1, joystick2, present}, last);
            end
            prev_clk  = joy_clk;
            prev_load = joy_load;
         end
      end
   end

   task automatic release_measure();
      int  n = 0;
      bit  seen = 0;
      @(negedge clk);
      reset = 1'b0;
      while (!seen && n < 5000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (u[0].scan_done) seen = 1;
      end
      check("first_scan_edge", 0, 33'(n), 33'(65 * 25 + 2));
   endtask

   task automatic wait_scans(input int n);
      int got = 0;
      int t = 0;
      while (got < n && t < n * 4000) begin
         @(negedge clk);
         t++;
         if (u[0].scan_done) got++;
      end
      if (got < n) check("wait_scan_timeout", 0, 33'(got), 33'(n));
   endtask

   initial begin
      int t;
      int r;
      logic pc;
      u[0].pat = {16'h8000, 16'h0011};
      u[1].pat = $urandom;
      repeat (3) @(negedge clk);
      release_measure();
      wait_scans(2);

      u[0].stuck = 1'b1;
      wait_scans(1);
      u[0].stuck = 1'b0;
      u[0].pat   = '0;
      wait_scans(1);

      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(50, 3000)) @(negedge clk);
         u[0].pat = (i == 3) ? 32'hFFFF_FFFF : $urandom;
         u[1].pat = $urandom;
      end
      wait_scans(1);

      u[0].pat = 32'h0000_00FF;
      wait_scans(2);
      check("pre_reset_out", 0, {u[0].joystick1, u[0].joystick2, u[0].present},
            {16'h00FF, 16'h0000, 1'b1});
      t = 0;
      while (u[0].joy_load && t < 5000) begin @(negedge clk); t++; end
      r  = 0;
      pc = u[0].joy_clk;
      while (r < 21 && t < 10000) begin
         @(negedge clk);
         t++;
         if (!pc && u[0].joy_clk) r++;
         pc = u[0].joy_clk;
      end
      check("rises_before_reset", 0, 33'(r), 33'd21);
      #2 reset = 1'b1;
      #1;
      check("reset_out", 0, {u[0].joystick1, u[0].joystick2, u[0].present}, 33'd0);
      check("reset_pins", 0, {30'd0, u[0].joy_clk, u[0].joy_load, u[0].scan_done},
            {30'd0, 1'b1, 1'b1, 1'b0});
      repeat (3) @(negedge clk);
      release_measure();

      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(50, 1500)) @(negedge clk);
         u[1].pat = $urandom;
      end
      wait_scans(2);
      check("inst1_frames", 1, 33'(u[1].scans >= 20), 33'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/joy_db15_scan.md
JOY_DB15_SCAN -- requirements
Module: joy_db15_scan

Interface
REQ-001 SHALL have parameter DIV, default 25; clk cycles per scan tick, legal range 2..255.
REQ-002 SHALL have parameter GAP, default 64; idle ticks between frames, legal range 1..1023.
REQ-003 SHALL have port clk, input, 1 bit; the single clock (40-50 MHz).
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port joy_data, input, 1 bit; serial data from the DB15 shift-register chain, low = pressed.
REQ-006 SHALL have port joy_clk, output, 1 bit; shift clock to the chain, idle high.
REQ-007 SHALL have port joy_load, output, 1 bit; parallel-load strobe to the chain, active low.
REQ-008 SHALL have port joystick1, output, 16 bits; player 1 buttons, 1 = pressed.
REQ-009 SHALL have port joystick2, output, 16 bits; player 2 buttons, 1 = pressed.
REQ-010 SHALL have port present, output, 1 bit; 1 = adapter detected in the last frame.
REQ-011 SHALL have port scan_done, output, 1 bit; one-clk pulse when outputs update.

Function
REQ-012 SHALL generate tick: divider counts 0..DIV-1 and asserts tick for one clk at DIV-1, then wraps to 0.
REQ-013 SHALL run states LOAD, SHIFT_LO, SHIFT_HI, PUBLISH, GAP; SHIFT_LO, SHIFT_HI, LOAD and GAP advance only on tick.
REQ-014 SHALL hold joy_load=0 and joy_clk=1 in LOAD; on tick go to SHIFT_LO with bit index 0 and joy_load=1.
REQ-015 SHALL hold joy_clk=0 in SHIFT_LO; on tick sample ~joy_data into shift bit[index], set joy_clk=1 and go to SHIFT_HI, all on the same clk edge.
REQ-016 SHALL hold joy_clk=1 in SHIFT_HI; on tick, if index=31 go to PUBLISH, else increment index and go to SHIFT_LO.
REQ-017 SHALL map sample n to joystick1[n] for n=0..15 and to joystick2[n-16] for n=16..31.
REQ-018 SHALL spend exactly one clk in PUBLISH, independent of tick, and go to GAP with the gap counter at 0.
REQ-019 SHALL, in PUBLISH, set present=0 and clear both joystick outputs if all 32 samples are 1 (joy_data stuck low, adapter absent/shorted); otherwise set present=1 and copy the shift register to the outputs.
REQ-020 SHALL pulse scan_done for the single clk following PUBLISH, in which the new outputs are first visible.
REQ-021 SHALL count GAP ticks and on the GAP-th tick go to LOAD; the divider is not reset by state changes.
REQ-022 SHALL hold joystick1, joystick2 and present stable outside the PUBLISH update; partial frames are never visible.
REQ-023 SHALL register joy_clk and joy_load (glitch-free); joy_data is sampled through a 2-flop synchronizer, and the sample taken in REQ-015 is the synchronizer output.
REQ-024 SHALL need 1 + 64 + GAP ticks plus 1 clk per frame (DIV=25, GAP=64: 3226 clk).

Reset
REQ-025 SHALL, while reset=1, force state=LOAD, divider=0, index=0, gap counter=0, joy_clk=1, joy_load=1, joystick1=0, joystick2=0, present=0, scan_done=0 and the shift register to 0.
REQ-026 SHALL, on reset assertion mid-frame (any state), abort immediately with no output update; after release the first frame starts in LOAD from divider 0.
REQ-027 SHALL, after reset release, first assert scan_done at clk 1+DIV*65+1 counted from the first rising edge with reset=0.

Verification
REQ-028 Shift-register model returns player1=16'h0011, player2=16'h8000 (pressed bits, active-low on wire) -> joystick1=16'h0011, joystick2=16'h8000, present=1, scan_done pulses once per frame.
REQ-029 joy_data held 0 all frame -> present=0, joystick1=joystick2=0; then model released to all-1 -> next frame present=1, outputs 0.
REQ-030 DIV=25: measure joy_load low 25 clk, joy_clk low/high 25/25 clk, 32 rising edges per frame, frame period 3226 clk.
REQ-031 Reset asserted during SHIFT_HI index 20 after a frame published 16'h00FF -> outputs 0 immediately, joy_clk=1, joy_load=1; first scan_done at clk 1627 after release.
REQ-032 Change model pattern mid-SHIFT -> outputs change only on scan_done clk; values reflect bits as sampled, never a mix across two published frames.
REQ-033 DIV=2, GAP=1 (minimum) -> correct data, frame period 133 clk, no missed or double scan_done.
